// File: rtl/gpmc_target.sv
// gpmc_target: GPMC synchronous responder on chip-select 1 of the ARM's
// multiplexed 16-bit AD bus. Each host access becomes a single-cycle write
// strobe or read request on the internal register bus. Read data is driven
// back onto the AD bus while the host still holds OE low.
//
// Build option: define GPMC_TARGET_BURST_EN to accept extra write data
// edges after the first one. Each extra edge writes to the next word address.
// Without the macro, extra data edges are ignored.
module gpmc_target #(
  parameter int unsigned RD_WAIT      = 3,
  parameter logic [15:0] TIMEOUT_DATA = 16'hDEAD,
  parameter logic [15:0] ADDR_MASK    = 16'hFFFE
) (
  input  logic        gpmc_clk,
  input  logic        reset_n,
  input  logic [15:0] gpmc_ad_in,
  output logic [15:0] gpmc_ad_out,
  output logic        gpmc_ad_oe,
  input  logic        gpmc_advn,
  input  logic        gpmc_csn,
  input  logic        gpmc_wein,
  input  logic        gpmc_oen,
  output logic [15:0] reg_addr,
  output logic        reg_wr_en,
  output logic [15:0] reg_wr_data,
  output logic        reg_rd_en,
  input  logic [15:0] reg_rd_data,
  input  logic        reg_rd_valid,
  output logic        err_timeout
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ADDR,
    S_WR_DONE,
    S_RD_WAIT,
    S_RD_HOLD
  } state_t;

  // The wait window covers RD_WAIT cycles, starting with the reg_rd_en cycle.
  // The timeout is taken on the last edge of the window, so the timeout data
  // is already stable before the host samples the bus.
  localparam logic [3:0] WAIT_LAST = 4'(RD_WAIT - 1);

  state_t     state;
  logic [3:0] wait_cnt;

  // Decode the bus phases, issue the register strobes and capture the read data.
  always_ff @(posedge gpmc_clk) begin
    if (!reset_n) begin
      state       <= S_IDLE;
      gpmc_ad_out <= '0;
      reg_addr    <= '0;
      reg_wr_data <= '0;
      reg_wr_en   <= 1'b0;
      reg_rd_en   <= 1'b0;
      err_timeout <= 1'b0;
      wait_cnt    <= '0;
    end else begin
      reg_wr_en   <= 1'b0;
      reg_rd_en   <= 1'b0;
      err_timeout <= 1'b0;
      if (gpmc_csn) begin
        state <= S_IDLE;
      end else begin
        case (state)
          S_IDLE: begin
            if (!gpmc_advn) begin
              reg_addr <= gpmc_ad_in & ADDR_MASK;
              if (gpmc_wein) state <= S_ADDR;
            end
          end
          S_ADDR: begin
            if (!gpmc_advn) begin
              reg_addr <= gpmc_ad_in & ADDR_MASK;
            end else if (!gpmc_wein) begin
              reg_wr_data <= gpmc_ad_in;
              reg_wr_en   <= 1'b1;
              state       <= S_WR_DONE;
            end else begin
              reg_rd_en <= 1'b1;
              wait_cnt  <= '0;
              state     <= S_RD_WAIT;
            end
          end
          S_WR_DONE: begin
`ifdef GPMC_TARGET_BURST_EN
            if (!gpmc_wein) begin
              reg_addr    <= reg_addr + 16'd2;
              reg_wr_data <= gpmc_ad_in;
              reg_wr_en   <= 1'b1;
            end
`else
            state <= S_WR_DONE;
`endif
          end
          S_RD_WAIT: begin
            if (reg_rd_valid) begin
              gpmc_ad_out <= reg_rd_data;
              state       <= S_RD_HOLD;
            end else if (wait_cnt == WAIT_LAST) begin
              gpmc_ad_out <= TIMEOUT_DATA;
              err_timeout <= 1'b1;
              state       <= S_RD_HOLD;
            end else begin
              wait_cnt <= wait_cnt + 4'd1;
            end
          end
          S_RD_HOLD: state <= S_RD_HOLD;
          default:   state <= S_IDLE;
        endcase
      end
    end
  end

  // Drive the pad only during a read phase, and only while the host holds CS and OE low.
  always_comb begin
    gpmc_ad_oe = ((state == S_RD_WAIT) || (state == S_RD_HOLD)) && !gpmc_csn && !gpmc_oen;
  end

endmodule
